// File: rtl/axi_lite_core_regs_pkg.sv
// Shared constants and FSM state types for the S00_AXI core register file.
// Offsets are byte addresses; decode uses only the word-select bits [4:2].
package axi_lite_core_regs_pkg;

    localparam logic [4:0] OFF_REG0   = 5'h00;
    localparam logic [4:0] OFF_REG1   = 5'h04;
    localparam logic [4:0] OFF_REG2   = 5'h08;
    localparam logic [4:0] OFF_REG3   = 5'h0C;
    localparam logic [4:0] OFF_CTRL   = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/axi_lite_core_regs_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the core register file.
interface axi_lite_core_regs_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_core_regs_core_status_tracker.sv
// Per-core start pulse, busy and sticky done tracking.
// A start to a busy core is dropped and flagged; done sets win over W1C clears.
module core_status_tracker #(
    parameter int N_CORES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CORES-1:0] start_req_i,
    input  logic [N_CORES-1:0] done_clr_i,
    input  logic [N_CORES-1:0] core_done_i,
    output logic [N_CORES-1:0] start_o,
    output logic [N_CORES-1:0] busy_o,
    output logic [N_CORES-1:0] done_o,
    output logic               start_err_o
);
    logic [N_CORES-1:0] start_q, start_d;
    logic [N_CORES-1:0] busy_q, busy_d;
    logic [N_CORES-1:0] done_q, done_d;
    logic [N_CORES-1:0] start_acc;

    always_comb begin
        start_acc   = start_req_i & ~busy_q;
        start_err_o = |(start_req_i & busy_q);
        start_d     = start_acc;
        busy_d      = (busy_q & ~core_done_i) | start_acc;
        done_d      = (done_q & ~done_clr_i) | core_done_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
endmodule

// File: rtl/axi_lite_core_regs.sv
// AXI4-Lite register file driving the four compute cores: operand registers,
// self-clearing start control and sticky done/busy status.
module axi_lite_core_regs
    import axi_lite_core_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int N_CORES            = 4
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    axi_lite_core_regs_if.slave                s_axi,
    output logic [3:0][C_S_AXI_DATA_WIDTH-1:0] operand_o,
    output logic [N_CORES-1:0]                 core_start_o,
    input  logic [N_CORES-1:0]                 core_done_i
);
    wr_state_e w_q, w_d;
    rd_state_e r_q, r_d;
    logic      live_q;
    logic      arready_q, arready_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
    logic wr_hs, rd_hs, wr_reg, wr_ctrl, wr_status;
    logic [N_CORES-1:0] start_req, done_clr, busy, done;
    logic start_err;
    logic unused_bits;

    assign awaddr    = s_axi.S_AXI_AWADDR;
    assign araddr    = s_axi.S_AXI_ARADDR;
    assign wr_reg    = awaddr[4:2] <= OFF_REG3[4:2];
    assign wr_ctrl   = awaddr[4:2] == OFF_CTRL[4:2];
    assign wr_status = awaddr[4:2] == OFF_STATUS[4:2];

    // Both channels must be valid together; live_q keeps ready low until reset is released.
    assign wr_hs = live_q && (w_q == W_IDLE) && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign rd_hs = arready_q && s_axi.S_AXI_ARVALID;

    assign start_req = (wr_hs && wr_ctrl && s_axi.S_AXI_WSTRB[0])
                     ? s_axi.S_AXI_WDATA[N_CORES-1:0] : '0;
    assign done_clr  = (wr_hs && wr_status && s_axi.S_AXI_WSTRB[0])
                     ? s_axi.S_AXI_WDATA[N_CORES-1:0] : '0;

    core_status_tracker #(.N_CORES(N_CORES)) u_tracker (
        .clk         (S_AXI_ACLK),
        .rst_n       (S_AXI_ARESETN),
        .start_req_i (start_req),
        .done_clr_i  (done_clr),
        .core_done_i (core_done_i),
        .start_o     (core_start_o),
        .busy_o      (busy),
        .done_o      (done),
        .start_err_o (start_err)
    );

    always_comb begin
        w_d     = w_q;
        bresp_d = bresp_q;
        regs_d  = regs_q;
        case (w_q)
            W_IDLE: begin
                if (wr_hs) begin
                    w_d     = W_RESP;
                    bresp_d = RESP_OKAY;
                    if (wr_reg) begin
                        for (int b = 0; b < 4; b++) begin
                            if (s_axi.S_AXI_WSTRB[b])
                                regs_d[awaddr[3:2]][8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
                        end
                    end else if (!wr_ctrl && !wr_status) begin
                        bresp_d = RESP_SLVERR;
                    end
                    if (start_err) bresp_d = RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) w_d = W_IDLE;
            end
        endcase
    end

    always_comb begin
        r_d       = r_q;
        arready_d = arready_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (rd_hs) begin
                    r_d       = R_DATA;
                    arready_d = 1'b0;
                    rresp_d   = RESP_OKAY;
                    rdata_d   = '0;
                    if (araddr[4:2] <= OFF_REG3[4:2]) begin
                        rdata_d = regs_q[araddr[3:2]];
                    end else if (araddr[4:2] == OFF_STATUS[4:2]) begin
                        rdata_d[2*N_CORES-1:0] = {busy, done};
                    end else if (araddr[4:2] != OFF_CTRL[4:2]) begin
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    r_d       = R_IDLE;
                    arready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_q       <= W_IDLE;
            r_q       <= R_IDLE;
            live_q    <= 1'b0;
            arready_q <= 1'b0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            regs_q    <= '0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            live_q    <= 1'b1;
            arready_q <= arready_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = wr_hs;
    assign s_axi.S_AXI_WREADY  = wr_hs;
    assign s_axi.S_AXI_BVALID  = (w_q == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = (r_q == R_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign operand_o           = regs_q;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr[1:0], araddr[1:0]};
endmodule
